// File: rtl/gpu_fb_pkg.sv
// Shared types and constants for the framebuffer write path onto the HPS f2h_sdram1 port.
package gpu_fb_pkg;
  localparam int FB_ADDR_W = 29;
  localparam int FB_DATA_W = 64;
  localparam int FB_BE_W   = FB_DATA_W / 8;
  localparam int FB_BC_W   = 8;

  localparam logic [FB_ADDR_W-1:0] FB_BASE_DEFAULT  = 29'h0780_0000;
  localparam int unsigned          FB_WORDS_DEFAULT = 153600;

  typedef enum logic [1:0] {ARB_IDLE, ARB_PIX, ARB_CLR} fb_arb_state_t;
  typedef enum logic {REQ_PIX, REQ_CLR} fb_req_t;

  // Next clear burst length: the full burst, or whatever is left of the framebuffer.
  function automatic logic [FB_BC_W-1:0] fb_burst_len(input logic [31:0] rem,
                                                      input int unsigned max_len);
    logic [31:0] lim;
    lim = max_len;
    return (rem < lim) ? rem[FB_BC_W-1:0] : lim[FB_BC_W-1:0];
  endfunction
endpackage

// File: rtl/fb_clear_sequencer.sv
// Framebuffer clear bookkeeping: colour latch, word pointer, remaining count and
// per-burst length; raises clear_busy for the whole fill and pulses clear_done at the end.
module fb_clear_sequencer
  import gpu_fb_pkg::*;
#(
  parameter int                 ADDR_W    = FB_ADDR_W,
  parameter int                 DATA_W    = FB_DATA_W,
  parameter int unsigned        BURST_LEN = 16,
  parameter logic [ADDR_W-1:0]  FB_BASE   = FB_BASE_DEFAULT,
  parameter int unsigned        FB_WORDS  = FB_WORDS_DEFAULT
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [DATA_W-1:0]   back_colour,
  input  logic                clear_start,
  input  logic                burst_done,
  output logic [ADDR_W-1:0]   ptr,
  output logic [FB_BC_W-1:0]  burstcount,
  output logic [DATA_W-1:0]   colour,
  output logic                clear_busy,
  output logic                clear_done
);
  logic [31:0] rem;
  logic [31:0] rem_next;

  // rem only moves at burst completion, so this stays constant across a burst.
  assign burstcount = fb_burst_len(rem, BURST_LEN);
  assign rem_next   = rem - 32'(burstcount);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ptr        <= '0;
      rem        <= '0;
      colour     <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      if (clear_start && !clear_busy) begin
        colour     <= back_colour;
        ptr        <= FB_BASE;
        rem        <= FB_WORDS;
        clear_busy <= 1'b1;
      end else if (burst_done) begin
        ptr <= ptr + ADDR_W'(burstcount);
        rem <= rem_next;
        if (rem_next == '0) begin
          clear_busy <= 1'b0;
          clear_done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin burst-boundary arbiter between rasterizer pixels and the clear engine on the
// f2h_sdram1 write port. Optional FB_WRITE_STATS_EN adds beat and stall counters.
module fb_write_arbiter
  import gpu_fb_pkg::*;
#(
  parameter int                 ADDR_W    = FB_ADDR_W,
  parameter int                 DATA_W    = FB_DATA_W,
  parameter int unsigned        BURST_LEN = 16,
  parameter logic [ADDR_W-1:0]  FB_BASE   = FB_BASE_DEFAULT,
  parameter int unsigned        FB_WORDS  = FB_WORDS_DEFAULT
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic [DATA_W-1:0]      back_colour,
  input  logic                   clear_start,
  output logic                   clear_busy,
  output logic                   clear_done,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  input  logic [ADDR_W-1:0]      pix_address,
  input  logic [DATA_W-1:0]      pix_data,
  input  logic [DATA_W/8-1:0]    pix_byteenable,
  output logic [ADDR_W-1:0]      avm_address,
  output logic [FB_BC_W-1:0]     avm_burstcount,
  output logic [DATA_W-1:0]      avm_writedata,
  output logic [DATA_W/8-1:0]    avm_byteenable,
  output logic                   avm_write,
  input  logic                   avm_waitrequest
`ifdef FB_WRITE_STATS_EN
  ,
  output logic [31:0]            stat_beats,
  output logic [31:0]            stat_stalls
`endif
);
  // state    | meaning
  // ARB_IDLE | no write in flight; arbitration runs every cycle
  // ARB_PIX  | single pixel beat on the bus, held until accepted
  // ARB_CLR  | clear burst on the bus, beat_cnt beats still to go
  fb_arb_state_t        state;
  fb_req_t              rr_last;
  logic [FB_BC_W-1:0]   beat_cnt;
  logic [ADDR_W-1:0]    clr_ptr;
  logic [FB_BC_W-1:0]   clr_burst;
  logic [DATA_W-1:0]    clr_colour;
  logic                 grant_pix;
  logic                 grant_clr;
  logic                 accept;
  logic                 burst_done;

  fb_clear_sequencer #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BURST_LEN (BURST_LEN),
    .FB_BASE   (FB_BASE),
    .FB_WORDS  (FB_WORDS)
  ) u_clear (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .back_colour   (back_colour),
    .clear_start   (clear_start),
    .burst_done    (burst_done),
    .ptr           (clr_ptr),
    .burstcount    (clr_burst),
    .colour        (clr_colour),
    .clear_busy    (clear_busy),
    .clear_done    (clear_done)
  );

  assign accept     = avm_write && !avm_waitrequest;
  assign burst_done = (state == ARB_CLR) && accept && (beat_cnt == 8'd1);

  // pix_ready is combinational, so it is held low through reset like every other output.
  assign grant_pix = reset_reset_n && (state == ARB_IDLE) && pix_valid &&
                     (!clear_busy || rr_last == REQ_CLR);
  assign grant_clr = (state == ARB_IDLE) && clear_busy &&
                     (!pix_valid || rr_last == REQ_PIX);
  assign pix_ready = grant_pix;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state          <= ARB_IDLE;
      rr_last        <= REQ_PIX;
      beat_cnt       <= '0;
      avm_address    <= '0;
      avm_burstcount <= 8'd1;
      avm_writedata  <= '0;
      avm_byteenable <= '0;
      avm_write      <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_pix) begin
            avm_address    <= pix_address;
            avm_burstcount <= 8'd1;
            avm_writedata  <= pix_data;
            avm_byteenable <= pix_byteenable;
            avm_write      <= 1'b1;
            rr_last        <= REQ_PIX;
            state          <= ARB_PIX;
          end else if (grant_clr) begin
            avm_address    <= clr_ptr;
            avm_burstcount <= clr_burst;
            avm_writedata  <= clr_colour;
            avm_byteenable <= '1;
            avm_write      <= 1'b1;
            beat_cnt       <= clr_burst;
            rr_last        <= REQ_CLR;
            state          <= ARB_CLR;
          end
        end
        ARB_PIX: begin
          if (!avm_waitrequest) begin
            avm_write <= 1'b0;
            state     <= ARB_IDLE;
          end
        end
        ARB_CLR: begin
          if (!avm_waitrequest) begin
            beat_cnt <= beat_cnt - 8'd1;
            if (beat_cnt == 8'd1) begin
              avm_write <= 1'b0;
              state     <= ARB_IDLE;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef FB_WRITE_STATS_EN
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stat_beats  <= '0;
      stat_stalls <= '0;
    end else begin
      if (accept && stat_beats != 32'hFFFF_FFFF)
        stat_beats <= stat_beats + 32'd1;
      if (avm_write && avm_waitrequest && stat_stalls != 32'hFFFF_FFFF)
        stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: transaction-level model (outstanding beats + clear burst list)
// checked every cycle, plus directed literal checks. Honours FB_WRITE_STATS_EN.
module tb_fb_write_arbiter;
  localparam logic [28:0] BASE       = 29'h0780_0000;
  localparam int          FB_WORDS_T = 40;
  localparam int          BURST_T    = 16;
  localparam logic [63:0] COL_A      = 64'h00FF_00FF_00FF_00FF;

  logic        clk_clk, reset_reset_n;
  logic [63:0] back_colour;
  logic        clear_start, clear_busy, clear_done;
  logic        pix_valid, pix_ready;
  logic [28:0] pix_address;
  logic [63:0] pix_data;
  logic [7:0]  pix_byteenable;
  logic [28:0] avm_address;
  logic [7:0]  avm_burstcount;
  logic [63:0] avm_writedata;
  logic [7:0]  avm_byteenable;
  logic        avm_write, avm_waitrequest;
`ifdef FB_WRITE_STATS_EN
  logic [31:0] stat_beats, stat_stalls;
`endif

  fb_write_arbiter #(.BURST_LEN(BURST_T), .FB_WORDS(FB_WORDS_T)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .back_colour(back_colour), .clear_start(clear_start),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_address(pix_address),
    .pix_data(pix_data), .pix_byteenable(pix_byteenable),
    .avm_address(avm_address), .avm_burstcount(avm_burstcount),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_write(avm_write), .avm_waitrequest(avm_waitrequest)
`ifdef FB_WRITE_STATS_EN
    , .stat_beats(stat_beats), .stat_stalls(stat_stalls)
`endif
  );

  initial begin
    clk_clk = 1'b0;
    forever #5 clk_clk = ~clk_clk;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", nm, act, exp);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed { logic [28:0] addr; logic [7:0] len; } burst_t;
  typedef struct packed { logic is_clr; logic [28:0] addr; logic [7:0] len; } txn_t;

  burst_t      clr_q[$];
  logic        m_busy, m_done, m_rr_clr, m_cur_clr;
  int          m_out;
  logic [28:0] m_addr;
  logic [7:0]  m_len, m_be;
  logic [63:0] m_data, m_colour;
  longint      m_beats, m_stalls;

  txn_t        txn_log[$];
  logic        prev_wr;
  int          n_wr, n_acc, n_acc_col, n_acc_ff, n_done;

  task automatic model_reset();
    clr_q.delete();
    m_busy = 0; m_done = 0; m_rr_clr = 0; m_cur_clr = 0; m_out = 0;
    m_addr = '0; m_len = 8'd1; m_be = '0; m_data = '0; m_colour = '0;
    m_beats = 0; m_stalls = 0; prev_wr = 0;
  endtask

  task automatic sample();
    logic   idle, g_pix, g_clr, acc, busy_now;
    burst_t b;
    txn_t   t;
    int     len;
    @(negedge clk_clk);
    if (!reset_reset_n) begin
      chk("rst_avm_write", 64'(avm_write), 64'd0);
      chk("rst_burstcount", 64'(avm_burstcount), 64'd1);
      chk("rst_address", 64'(avm_address), 64'd0);
      chk("rst_writedata", avm_writedata, 64'd0);
      chk("rst_byteenable", 64'(avm_byteenable), 64'd0);
      chk("rst_pix_ready", 64'(pix_ready), 64'd0);
      chk("rst_clear_busy", 64'(clear_busy), 64'd0);
      chk("rst_clear_done", 64'(clear_done), 64'd0);
`ifdef FB_WRITE_STATS_EN
      chk("rst_stat_beats", 64'(stat_beats), 64'd0);
      chk("rst_stat_stalls", 64'(stat_stalls), 64'd0);
`endif
      model_reset();
      return;
    end
    if (avm_write && !prev_wr) begin
      t.is_clr = (avm_burstcount != 8'd1); t.addr = avm_address; t.len = avm_burstcount;
      txn_log.push_back(t);
    end
    prev_wr = avm_write;
    if (avm_write) n_wr++;
    if (avm_write && !avm_waitrequest) begin
      n_acc++;
      if (avm_writedata == COL_A) n_acc_col++;
      if (avm_byteenable == 8'hFF) n_acc_ff++;
    end
    if (clear_done) n_done++;

    idle  = (m_out == 0);
    g_pix = idle && pix_valid && (!m_busy || m_rr_clr);
    g_clr = idle && m_busy && (clr_q.size() > 0) && (!pix_valid || !m_rr_clr);
    chk("pix_ready", 64'(pix_ready), 64'(g_pix));
    chk("avm_write", 64'(avm_write), 64'(m_out > 0));
    chk("clear_busy", 64'(clear_busy), 64'(m_busy));
    chk("clear_done", 64'(clear_done), 64'(m_done));
    if (m_out > 0) begin
      chk("avm_address", 64'(avm_address), 64'(m_addr));
      chk("avm_burstcount", 64'(avm_burstcount), 64'(m_len));
      chk("avm_writedata", avm_writedata, m_data);
      chk("avm_byteenable", 64'(avm_byteenable), 64'(m_be));
    end
`ifdef FB_WRITE_STATS_EN
    chk("stat_beats", 64'(stat_beats), 64'(m_beats));
    chk("stat_stalls", 64'(stat_stalls), 64'(m_stalls));
`endif

    busy_now = m_busy;
    acc = (m_out > 0) && !avm_waitrequest;
    if (m_out > 0) begin
      if (acc) m_beats++;
      else m_stalls++;
    end
    m_done = 0;
    if (acc) begin
      m_out--;
      if (m_out == 0 && m_cur_clr && clr_q.size() == 0) begin
        m_busy = 0;
        m_done = 1;
      end
    end
    if (clear_start && !busy_now) begin
      m_colour = back_colour;
      clr_q.delete();
      for (int off = 0; off < FB_WORDS_T; off += BURST_T) begin
        len = (FB_WORDS_T - off < BURST_T) ? FB_WORDS_T - off : BURST_T;
        b.addr = BASE + 29'(off);
        b.len  = 8'(len);
        clr_q.push_back(b);
      end
      m_busy = 1;
    end
    if (g_pix) begin
      m_cur_clr = 0; m_addr = pix_address; m_len = 8'd1; m_data = pix_data;
      m_be = pix_byteenable; m_out = 1; m_rr_clr = 0;
    end else if (g_clr) begin
      b = clr_q.pop_front();
      m_cur_clr = 1; m_addr = b.addr; m_len = b.len; m_data = m_colour;
      m_be = 8'hFF; m_out = int'(b.len); m_rr_clr = 1;
    end
  endtask

  task automatic next();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      next();
    end
  endtask

  task automatic run_until_done(input int budget, input string nm);
    logic found;
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      sample();
      found = clear_done;
      next();
    end
    chk(nm, 64'(found), 64'd1);
  endtask

  int   s_wr, s_acc, s_col, s_ff, s_done, s_log;
  logic got;

  initial begin
    model_reset();
    n_wr = 0; n_acc = 0; n_acc_col = 0; n_acc_ff = 0; n_done = 0;
    reset_reset_n = 0; back_colour = '0; clear_start = 0; pix_valid = 0;
    pix_address = '0; pix_data = '0; pix_byteenable = '0; avm_waitrequest = 0;
    cycles(2);
    reset_reset_n = 1;

    // single pixel, no stall
    pix_valid = 1; pix_address = 29'h100; pix_data = 64'hA5; pix_byteenable = 8'hFF;
    sample();
    chk("px_ready_c0", 64'(pix_ready), 64'd1);
    next();
    pix_valid = 0;
    sample();
    chk("px_write_c1", 64'(avm_write), 64'd1);
    chk("px_burst_c1", 64'(avm_burstcount), 64'd1);
    chk("px_addr_c1", 64'(avm_address), 64'h100);
    chk("px_data_c1", avm_writedata, 64'hA5);
    next();
    sample();
    chk("px_write_c2", 64'(avm_write), 64'd0);
    next();

    // pixel under 3 cycles of waitrequest
    s_wr = n_wr; s_acc = n_acc;
    pix_valid = 1; pix_address = 29'h200; pix_data = {$urandom, $urandom}; avm_waitrequest = 1;
    sample();
    chk("stall_ready", 64'(pix_ready), 64'd1);
    next();
    pix_valid = 0;
    cycles(3);
    avm_waitrequest = 0;
    cycles(2);
    chk("stall_write_cycles", 64'(n_wr - s_wr), 64'd4);
    chk("stall_accepts", 64'(n_acc - s_acc), 64'd1);

    // full clear, restart attempt mid-clear with another colour
    s_acc = n_acc; s_col = n_acc_col; s_ff = n_acc_ff; s_done = n_done; s_log = txn_log.size();
    back_colour = COL_A; clear_start = 1;
    sample(); next();
    clear_start = 0; back_colour = 64'h1234_5678_9ABC_DEF0;
    cycles(10);
    clear_start = 1;
    sample(); next();
    clear_start = 0;
    run_until_done(300, "clear_done_timeout");
    cycles(3);
    chk("clr_bursts", 64'(txn_log.size() - s_log), 64'd3);
    if (txn_log.size() - s_log >= 3) begin
      chk("clr_b0_addr", 64'(txn_log[s_log].addr), 64'(BASE));
      chk("clr_b1_addr", 64'(txn_log[s_log+1].addr), 64'(BASE + 29'd16));
      chk("clr_b2_addr", 64'(txn_log[s_log+2].addr), 64'(BASE + 29'd32));
      chk("clr_b0_len", 64'(txn_log[s_log].len), 64'd16);
      chk("clr_b1_len", 64'(txn_log[s_log+1].len), 64'd16);
      chk("clr_b2_len", 64'(txn_log[s_log+2].len), 64'd8);
    end
    chk("clr_beats", 64'(n_acc - s_acc), 64'd40);
    chk("clr_beats_ff", 64'(n_acc_ff - s_ff), 64'd40);
    chk("clr_beats_colour", 64'(n_acc_col - s_col), 64'd40);
    chk("clr_done_pulses", 64'(n_done - s_done), 64'd1);

    // contention: pixels requested continuously during a clear
    s_log = txn_log.size();
    back_colour = {$urandom, $urandom}; clear_start = 1;
    sample(); next();
    clear_start = 0;
    sample(); next();
    pix_valid = 1; pix_address = 29'($urandom); pix_data = {$urandom, $urandom};
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      sample();
      got = clear_done;
      next();
      pix_address = 29'($urandom); pix_data = {$urandom, $urandom};
    end
    chk("cont_done_timeout", 64'(got), 64'd1);
    pix_valid = 0;
    cycles(4);
    chk("cont_enough_txns", 64'(txn_log.size() - s_log >= 4), 64'd1);
    if (txn_log.size() - s_log >= 4) begin
      chk("cont_g0_clr", 64'(txn_log[s_log].is_clr), 64'd1);
      chk("cont_g1_pix", 64'(txn_log[s_log+1].is_clr), 64'd0);
      chk("cont_g2_clr", 64'(txn_log[s_log+2].is_clr), 64'd1);
      chk("cont_g3_pix", 64'(txn_log[s_log+3].is_clr), 64'd0);
    end

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      pix_valid       = ($urandom % 2) == 0;
      pix_address     = 29'($urandom);
      pix_data        = {$urandom, $urandom};
      pix_byteenable  = 8'($urandom);
      avm_waitrequest = ($urandom % 10) < 3;
      clear_start     = ($urandom % 40) == 0;
      back_colour     = {$urandom, $urandom};
      sample(); next();
    end
    pix_valid = 0; clear_start = 0; avm_waitrequest = 0;
    run_until_done(200, "rand_drain");
    cycles(2);

    // reset during the fifth clear beat
    s_acc = n_acc;
    back_colour = COL_A; clear_start = 1;
    sample(); next();
    clear_start = 0;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      sample();
      got = (n_acc - s_acc) >= 5;
      next();
    end
    chk("rst_reach_beat5", 64'(got), 64'd1);
    reset_reset_n = 0;
    #1;
    chk("midrst_write", 64'(avm_write), 64'd0);
    chk("midrst_busy", 64'(clear_busy), 64'd0);
`ifdef FB_WRITE_STATS_EN
    chk("midrst_stat_beats", 64'(stat_beats), 64'd0);
`endif
    cycles(2);
    reset_reset_n = 1;
    cycles(1);
    s_log = txn_log.size();
    clear_start = 1;
    sample(); next();
    clear_start = 0;
    run_until_done(200, "post_rst_done");
    chk("post_rst_has_txn", 64'(txn_log.size() > s_log), 64'd1);
    if (txn_log.size() > s_log) begin
      chk("post_rst_base", 64'(txn_log[s_log].addr), 64'(BASE));
      chk("post_rst_len", 64'(txn_log[s_log].len), 64'd16);
    end
    cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
